// File: rtl/sv12_lrm_p0639_demux1to2_stream_if.sv
// Stream bundle for the 1-to-2 demux.
// One input valid/ready stream with a routing select, and two output valid/ready streams.
// The master side drives the input stream and the output readies.
// The slave side is the demux itself.
interface sv12_lrm_p0639_demux1to2_stream_if #(
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sel;
    logic          in_last;

    logic          out0_valid;
    logic          out0_ready;
    logic [DW-1:0] out0_data;
    logic          out0_last;

    logic          out1_valid;
    logic          out1_ready;
    logic [DW-1:0] out1_data;
    logic          out1_last;

    modport master (
        output in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
    );
endinterface

// File: rtl/sv12_lrm_p0639_demux1to2_stream.sv
// Registered 1-to-2 packet demultiplexer.
// Each input packet is steered whole to out0 or out1.
// The destination is taken from in_sel on the first beat of the packet.
// Each output has a 2-entry {data,last} buffer and a saturating delivered-packet counter.
module sv12_lrm_p0639_demux1to2_stream #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    sv12_lrm_p0639_demux1to2_stream_if.slave  bus,
    output logic [CW-1:0]                     pkt_cnt0,
    output logic [CW-1:0]                     pkt_cnt1,
    output logic                              busy
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e        state_q, state_d;
    logic          locked_sel_q, locked_sel_d;

    // Per-output buffer storage, indexed [output][entry].
    logic [DW-1:0] mem_data_q [2][2];
    logic          mem_last_q [2][2];
    logic [1:0]    rptr_q;          // bit k is the read pointer of buffer k
    logic [1:0]    wptr_q;          // bit k is the write pointer of buffer k
    logic [1:0]    count_q [2];
    logic [CW-1:0] cnt_q [2];

    logic          eff_sel;
    logic          in_ready;
    logic          accept;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    out_valid;
    logic [1:0]    out_ready;
    logic [1:0]    hidx;
    logic [DW-1:0] head_data [2];
    logic [1:0]    head_last;

    // Route select and input acceptance.
    // in_ready looks only at the target buffer's occupancy, never at in_valid.
    always_comb begin
        eff_sel  = (state_q == StLock) ? locked_sel_q : bus.in_sel;
        in_ready = rst_n && (count_q[eff_sel] < 2'd2);
        accept   = bus.in_valid && in_ready;
    end

    // Per-output push/pop strobes and head-of-buffer selection.
    always_comb begin
        out_ready = {bus.out1_ready, bus.out0_ready};
        for (int k = 0; k < 2; k++) begin
            out_valid[k] = (count_q[k] != 2'd0);
            push[k]      = accept && (eff_sel == 1'(k));
            pop[k]       = out_valid[k] && out_ready[k];
            // Once empty, point at the entry just popped so data/last hold their last value.
            hidx[k]      = (count_q[k] == 2'd0) ? ~rptr_q[k] : rptr_q[k];
            head_data[k] = mem_data_q[k][hidx[k]];
            head_last[k] = mem_last_q[k][hidx[k]];
        end
    end

    // Buffer storage, pointers and occupancy; pointers wrap modulo 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            for (int k = 0; k < 2; k++) begin
                count_q[k] <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    mem_data_q[k][e] <= '0;
                    mem_last_q[k][e] <= 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem_data_q[k][wptr_q[k]] <= bus.in_data;
                    mem_last_q[k][wptr_q[k]] <= bus.in_last;
                    wptr_q[k]                <= ~wptr_q[k];
                end
                if (pop[k]) begin
                    rptr_q[k] <= ~rptr_q[k];
                end
                if (push[k] && !pop[k]) begin
                    count_q[k] <= count_q[k] + 2'd1;
                end else if (!push[k] && pop[k]) begin
                    count_q[k] <= count_q[k] - 2'd1;
                end
            end
        end
    end

    // Delivered-packet counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pop[k] && head_last[k] && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + CW'(1);
                end
            end
        end
    end

    // FSM state and packet-lock register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            locked_sel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_sel_q <= locked_sel_d;
        end
    end

    // FSM next state: lock on a multi-beat first beat, unlock on the last beat.
    always_comb begin
        state_d      = state_q;
        locked_sel_d = locked_sel_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !bus.in_last) begin
                    state_d      = StLock;
                    locked_sel_d = bus.in_sel;
                end
            end
            StLock: begin
                if (accept && bus.in_last) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // FSM output.
    always_comb begin
        busy = (state_q == StLock);
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_valid = out_valid[0];
    assign bus.out0_data  = head_data[0];
    assign bus.out0_last  = head_last[0];
    assign bus.out1_valid = out_valid[1];
    assign bus.out1_data  = head_data[1];
    assign bus.out1_last  = head_last[1];
    assign pkt_cnt0       = cnt_q[0];
    assign pkt_cnt1       = cnt_q[1];

endmodule

// File: tb/tb_sv12_lrm_p0639_demux1to2_stream.sv
// Self-checking bench for the 1-to-2 packet demux.
// A queue-based model of the two output buffers is compared against the DUT on every falling edge.
// Directed sequences add literal expectations on top of that comparison.
module tb_sv12_lrm_p0639_demux1to2_stream;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;
    logic          busy;

    int nvec = 0;
    int nerr = 0;

    // Model: per-output queues of {last,data}, delivered-packet counts, and packet lock.
    logic [DW:0] mq0[$];
    logic [DW:0] mq1[$];
    int          m_cnt0 = 0;
    int          m_cnt1 = 0;
    bit          m_lock = 1'b0;
    bit          m_lsel = 1'b0;

    sv12_lrm_p0639_demux1to2_stream_if #(.DW(DW)) bus ();

    sv12_lrm_p0639_demux1to2_stream #(
        .DW(DW),
        .CW(CW)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=0x%0h want=0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int qsize(input bit k);
        return k ? mq1.size() : mq0.size();
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_lock = 1'b0;
        m_lsel = 1'b0;
    endtask

    task automatic model_step();
        bit          eff;
        bit          acc;
        logic [DW:0] it;
        eff = m_lock ? m_lsel : bus.in_sel;
        acc = bus.in_valid && (qsize(eff) < 2);
        if (mq0.size() > 0 && bus.out0_ready) begin
            it = mq0.pop_front();
            if (it[DW] && m_cnt0 < CMAX) m_cnt0++;
        end
        if (mq1.size() > 0 && bus.out1_ready) begin
            it = mq1.pop_front();
            if (it[DW] && m_cnt1 < CMAX) m_cnt1++;
        end
        if (acc) begin
            if (eff) mq1.push_back({bus.in_last, bus.in_data});
            else     mq0.push_back({bus.in_last, bus.in_data});
            if (!m_lock && !bus.in_last) begin
                m_lock = 1'b1;
                m_lsel = bus.in_sel;
            end else if (m_lock && bus.in_last) begin
                m_lock = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        bit          eff;
        logic [DW:0] h;
        eff = m_lock ? m_lsel : bus.in_sel;
        chk("in_ready", 32'(bus.in_ready), 32'(rst_n && (qsize(eff) < 2)));
        chk("busy", 32'(busy), 32'(m_lock));
        chk("out0_valid", 32'(bus.out0_valid), 32'(mq0.size() != 0));
        chk("out1_valid", 32'(bus.out1_valid), 32'(mq1.size() != 0));
        if (mq0.size() != 0) begin
            h = mq0[0];
            chk("out0_data", 32'(bus.out0_data), 32'(h[DW-1:0]));
            chk("out0_last", 32'(bus.out0_last), 32'(h[DW]));
        end else if (!rst_n) begin
            chk("out0_data_rst", 32'(bus.out0_data), 32'd0);
            chk("out0_last_rst", 32'(bus.out0_last), 32'd0);
        end
        if (mq1.size() != 0) begin
            h = mq1[0];
            chk("out1_data", 32'(bus.out1_data), 32'(h[DW-1:0]));
            chk("out1_last", 32'(bus.out1_last), 32'(h[DW]));
        end else if (!rst_n) begin
            chk("out1_data_rst", 32'(bus.out1_data), 32'd0);
            chk("out1_last_rst", 32'(bus.out1_last), 32'd0);
        end
        chk("pkt_cnt0", 32'(pkt_cnt0), 32'(m_cnt0));
        chk("pkt_cnt1", 32'(pkt_cnt1), 32'(m_cnt1));
    endtask

    // Model update on each rising edge, cleared immediately by an asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare DUT against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check_all();
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Hold a beat until accepted; call and return 1 time unit after a rising edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic l);
        bit acc;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_last  = l;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            sync();
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout t=%0t got=no-accept want=accept data=0x%0h", $time, d);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin : stim
        int          sat_exp[5];
        time         t0;
        time         t1;
        sat_exp = '{1, 2, 3, 3, 3};
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_sel     = 1'b0;
        bus.in_last    = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-beat packets on consecutive cycles.
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h11;
        bus.in_sel     = 1'b0;
        bus.in_last    = 1'b1;
        sync();
        bus.in_data = 8'h22;
        bus.in_sel  = 1'b1;
        @(negedge clk);
        chk("sb_out0_valid", 32'(bus.out0_valid), 32'd1);
        chk("sb_out0_data", 32'(bus.out0_data), 32'h11);
        sync();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sb_out1_data", 32'(bus.out1_data), 32'h22);
        chk("sb_pkt_cnt0", 32'(pkt_cnt0), 32'd1);
        sync();
        @(negedge clk);
        chk("sb_pkt_cnt1", 32'(pkt_cnt1), 32'd1);
        chk("sb_busy", 32'(busy), 32'd0);
        sync();

        // Packet lock: select toggles after the first beat but the packet stays on out1.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA0 + 8'(i);
            bus.in_sel   = (i % 2 == 0);
            bus.in_last  = (i == 3);
            if (i > 0) begin
                @(negedge clk);
                chk("lk_out1_data", 32'(bus.out1_data), 32'hA0 + 32'(i - 1));
                chk("lk_out1_last", 32'(bus.out1_last), 32'd0);
                chk("lk_busy", 32'(busy), 32'd1);
            end
            sync();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lk_out1_data3", 32'(bus.out1_data), 32'hA3);
        chk("lk_out1_last3", 32'(bus.out1_last), 32'd1);
        chk("lk_busy_end", 32'(busy), 32'd0);
        chk("lk_out0_valid", 32'(bus.out0_valid), 32'd0);
        sync();

        // Backpressure on out0 with a 3-beat packet.
        bus.out0_ready = 1'b0;
        send_beat(8'hB0, 1'b0, 1'b0);
        send_beat(8'hB1, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB2;
        bus.in_sel   = 1'b1;
        bus.in_last  = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_out0_hold", 32'(bus.out0_data), 32'hB0);
        sync();
        bus.out0_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_nopass", 32'(bus.in_ready), 32'd0);
        sync();
        @(negedge clk);
        chk("bp_in_ready_after_pop", 32'(bus.in_ready), 32'd1);
        chk("bp_out0_data1", 32'(bus.out0_data), 32'hB1);
        sync();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out0_data2", 32'(bus.out0_data), 32'hB2);
        chk("bp_busy", 32'(busy), 32'd0);
        repeat (2) sync();

        // Independent drain: out0 full and stalled while out1 streams.
        bus.out0_ready = 1'b0;
        send_beat(8'hC0, 1'b0, 1'b1);
        send_beat(8'hC1, 1'b0, 1'b1);
        t0 = $time;
        for (int i = 0; i < 4; i++) send_beat(8'hD0 + 8'(i), 1'b1, (i == 3));
        t1 = $time;
        chk("dr_rate_cycles", 32'((t1 - t0) / 10), 32'd4);
        @(negedge clk);
        chk("dr_out0_hold", 32'(bus.out0_data), 32'hC0);
        chk("dr_out0_valid", 32'(bus.out0_valid), 32'd1);
        sync();
        bus.out0_ready = 1'b1;
        repeat (4) sync();

        // Counter saturation after a fresh reset.
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_beat(8'h50 + 8'(i), 1'b0, 1'b1);
            @(posedge clk);
            @(negedge clk);
            chk("sat_pkt_cnt0", 32'(pkt_cnt0), 32'(sat_exp[i]));
            sync();
        end

        // Asynchronous reset in the middle of a packet.
        bus.out1_ready = 1'b0;
        send_beat(8'hE0, 1'b1, 1'b0);
        send_beat(8'hE1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("rs_out1_data", 32'(bus.out1_data), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rs_pkt_cnt0", 32'(pkt_cnt0), 32'd0);
        sync();
        rst_n = 1'b1;
        bus.out0_ready = 1'b0;
        send_beat(8'hE5, 1'b0, 1'b1);
        @(negedge clk);
        chk("rs_new_out0_valid", 32'(bus.out0_valid), 32'd1);
        chk("rs_new_out0_data", 32'(bus.out0_data), 32'hE5);
        chk("rs_new_out1_valid", 32'(bus.out1_valid), 32'd0);
        sync();

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid   = ($urandom_range(0, 9) < 7);
            bus.in_data    = DW'($urandom);
            bus.in_sel     = 1'($urandom_range(0, 1));
            bus.in_last    = ($urandom_range(0, 3) == 0);
            bus.out0_ready = ($urandom_range(0, 9) < 6);
            bus.out1_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst_n = 1'b0;
                sync();
                rst_n = 1'b1;
            end else begin
                sync();
            end
        end

        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        repeat (4) sync();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sv12_lrm_p0639_demux1to2_stream.md
Name: sv12_lrm_p0639_demux1to2_stream

Overview:
Registered 1-to-2 stream demultiplexer. It is the distributing counterpart of the 2-to-1 mux used by the include-file top level. One valid/ready input stream is steered, one whole packet at a time, to one of two valid/ready output streams. Each output has a 2-entry buffer and a saturating packet counter, so a test program can check routing.

Parameters:
- DW, 8, data width in bits.
- CW, 8, width of each per-output packet counter.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, input beat accepted when in_valid && in_ready.
- in_data, input, DW, input beat data.
- in_sel, input, 1, destination (0 → out0, 1 → out1); sampled only on the first beat of a packet.
- in_last, input, 1, marks the final beat of a packet.
- out0_valid, output, 1, out0 beat valid.
- out0_ready, input, 1, out0 downstream ready.
- out0_data, output, DW, out0 beat data.
- out0_last, output, 1, out0 end of packet.
- out1_valid, output, 1, out1 beat valid.
- out1_ready, input, 1, out1 downstream ready.
- out1_data, output, DW, out1 beat data.
- out1_last, output, 1, out1 end of packet.
- pkt_cnt0, output, CW, packets delivered on out0 (saturating).
- pkt_cnt1, output, CW, packets delivered on out1 (saturating).
- busy, output, 1, high while a multi-beat packet is in progress (state LOCK).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, both buffers empty, locked_sel=0.
  - All outputs 0: out*_valid, out*_data, out*_last, pkt_cnt*, busy.
  - in_ready=0 during reset.
  - Reset mid-packet discards all buffered beats and the lock.
- Routing select:
  - eff_sel = in_sel in IDLE; eff_sel = locked_sel in LOCK.
- State machine:
  - IDLE, accepted beat with in_last=0 → LOCK, locked_sel<=in_sel.
  - IDLE, accepted beat with in_last=1 → stay IDLE (single-beat packet).
  - LOCK, accepted beat with in_last=1 → IDLE.
  - In LOCK, in_sel is ignored.
  - busy = (state==LOCK).
- in_ready:
  - in_ready = rst_n && (count[eff_sel] < 2).
  - Combinational from state and buffer counts only; never depends on in_valid.
  - No same-cycle pass-through on a full buffer: a full buffer deasserts in_ready even if its out*_ready=1 that cycle.
- Buffers:
  - Each output has a 2-entry FIFO of {data,last}; its count is 0..2.
  - out*_valid = (count!=0); out*_data/out*_last come from the head entry, registered.
  - Push and pop in the same cycle leave the count unchanged; read/write pointers wrap modulo 2.
  - Latency: a beat accepted at edge N is visible on its output after edge N (one cycle).
  - Throughput: 1 beat/cycle sustained when downstream holds ready=1.
  - Output data/last are held stable while valid && !ready.
  - The unselected output's buffer keeps draining independently.
  - When count returns to 0, data/last hold their last value; they are don't-care while valid=0.
- Packet counters:
  - pkt_cnt_k increments when out_k_valid && out_k_ready && out_k_last.
  - Saturates at 2^CW-1 (no wrap).
- Simultaneous events:
  - A push to one buffer and a pop from the other in the same cycle are independent.
  - A last-beat acceptance and a new first beat cannot occur in the same cycle (one beat per cycle).

Test Plan:
- Single-beat packets: reset, then beats D=0x11 sel=0 last=1 and D=0x22 sel=1 last=1 on consecutive cycles, both outputs ready=1 → out0 shows 0x11 one cycle after acceptance, out1 shows 0x22 the following cycle; pkt_cnt0=1, pkt_cnt1=1; busy stays 0.
- Packet lock: 4-beat packet 0xA0..0xA3 with in_sel=1 on beat 0, in_sel toggled on beats 1–3 → all four beats appear on out1 with last only on 0xA3; busy=1 from after beat 0 until after beat 3; out0_valid stays 0.
- Backpressure: out0_ready=0, send 3-beat packet to out0 → in_ready drops after 2 beats accepted and out0_data holds 0x?0; raise out0_ready → the third beat is accepted the cycle after the first pop; order is preserved.
- Independent drain: out0 full and stalled while a packet is sent to out1 with out1_ready=1 → out1 streams at 1 beat/cycle; out0 contents are unchanged.
- Counter saturation: CW=2, send 5 single-beat packets to out0 → pkt_cnt0 reads 1,2,3,3,3.
- Reset mid-packet: assert rst_n=0 asynchronously after beat 1 of a 4-beat packet → all outputs are 0 immediately; after release, state=IDLE and the next beat's in_sel is honoured.
